// File: rtl/wash_sequencer_pkg.sv
// Shared definitions for the wash sequencer: phase encodings and per-mode programme tables.
package wash_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FILL   = 3'd1,
        PH_WASH   = 3'd2,
        PH_RINSE  = 3'd3,
        PH_SPIN   = 3'd4,
        PH_DRAIN  = 3'd5,
        PH_DONE   = 3'd6,
        PH_PAUSED = 3'd7
    } phase_t;

    function automatic logic [7:0] wash_secs(input logic [1:0] mode);
        case (mode)
            2'b01:   return 8'd5;
            2'b10:   return 8'd8;
            2'b11:   return 8'd12;
            default: return 8'd0;
        endcase
    endfunction

    // Whole-programme totals shown on the display at start, already in BCD.
    function automatic logic [11:0] total_bcd(input logic [1:0] mode);
        case (mode)
            2'b01:   return 12'h020;
            2'b10:   return 12'h023;
            2'b11:   return 12'h027;
            default: return 12'h008;
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_FILL:  return PH_WASH;
            PH_WASH:  return PH_RINSE;
            PH_RINSE: return PH_SPIN;
            PH_SPIN:  return PH_DRAIN;
            PH_DRAIN: return PH_DONE;
            default:  return PH_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] light_of(input phase_t p);
        case (p)
            PH_FILL:   return 8'h01;
            PH_WASH:   return 8'h02;
            PH_RINSE:  return 8'h04;
            PH_SPIN:   return 8'h08;
            PH_DRAIN:  return 8'h10;
            PH_PAUSED: return 8'h80;
            default:   return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Control/status bundle between the billing-side controller and the wash sequencer.
interface wash_sequencer_if;
    logic        start;
    logic [1:0]  mode;
    logic        pause_p;
    logic        door_open;
    logic        busy;
    logic        done;
    logic [2:0]  phase;
    logic [11:0] remain;
    logic [7:0]  ph_light;
    logic        buzz_en;

    modport master (output start, mode, pause_p, door_open,
                    input  busy, done, phase, remain, ph_light, buzz_en);
    modport slave  (input  start, mode, pause_p, door_open,
                    output busy, done, phase, remain, ph_light, buzz_en);
endinterface

// File: rtl/wash_sequencer_bcd.sv
// Three-digit BCD down-counter with load; holds at 000 instead of wrapping.
module bcd_down3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [11:0] load_val,
    input  logic        dec,
    output logic [11:0] q,
    output logic        zero
);
    assign zero = (q == 12'h000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 12'h000;
        end else if (load) begin
            q <= load_val;
        end else if (dec && !zero) begin
            if (q[3:0] != 4'd0) begin
                q[3:0] <= q[3:0] - 4'd1;
            end else begin
                q[3:0] <= 4'd9;
                if (q[7:4] != 4'd0) begin
                    q[7:4] <= q[7:4] - 4'd1;
                end else begin
                    q[7:4]  <= 4'd9;
                    q[11:8] <= q[11:8] - 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/wash_sequencer.sv
// Wash programme sequencer: 1 s tick divider, phase FSM with pause/resume, BCD time-left display.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int T_FILL   = 3,
    parameter int T_RINSE  = 4,
    parameter int T_SPIN   = 6,
    parameter int T_DRAIN  = 2,
    parameter int T_DONE   = 3
) (
    input logic              clk,
    input logic              rst,
    wash_sequencer_if.slave  bus
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    phase_t        state, saved, nxt_state, nxt_saved, adv, start_ph;
    logic [7:0]    cnt, nxt_cnt, wash_len;
    logic [DW-1:0] div;
    logic          run, counting, tick, start_ok, rem_zero;

    function automatic logic [7:0] dur(input phase_t p, input logic [7:0] wl);
        case (p)
            PH_FILL:  return 8'(T_FILL);
            PH_WASH:  return wl;
            PH_RINSE: return 8'(T_RINSE);
            PH_SPIN:  return 8'(T_SPIN);
            PH_DRAIN: return 8'(T_DRAIN);
            PH_DONE:  return 8'(T_DONE);
            default:  return 8'd0;
        endcase
    endfunction

    assign run      = state inside {PH_FILL, PH_WASH, PH_RINSE, PH_SPIN, PH_DRAIN};
    assign counting = run || (state == PH_DONE);
    assign tick     = counting && (div == DW'(TICK_DIV - 1));
    assign start_ok = (state == PH_IDLE) && bus.start && !bus.door_open;
    assign start_ph = (bus.mode == 2'b00) ? PH_SPIN : PH_FILL;
    assign adv      = next_phase(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if (start_ok)
            div <= '0;
        else if (counting)
            div <= tick ? '0 : div + 1'b1;
    end

    // A tick landing together with a pause request is applied first, so the
    // phase saved for resume is the one the tick advanced into.
    always_comb begin
        nxt_state = state;
        nxt_saved = saved;
        nxt_cnt   = cnt;
        case (state)
            PH_IDLE: begin
                if (start_ok) begin
                    nxt_state = start_ph;
                    nxt_cnt   = dur(start_ph, wash_len);
                end
            end
            PH_PAUSED: begin
                if (bus.pause_p && !bus.door_open)
                    nxt_state = saved;
            end
            PH_DONE: begin
                if (tick) begin
                    if (cnt == 8'd1) begin
                        nxt_state = PH_IDLE;
                        nxt_cnt   = 8'd0;
                    end else begin
                        nxt_cnt = cnt - 8'd1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (cnt == 8'd1) begin
                        nxt_state = adv;
                        nxt_cnt   = dur(adv, wash_len);
                    end else begin
                        nxt_cnt = cnt - 8'd1;
                    end
                end
                if (nxt_state != PH_DONE && (bus.pause_p || bus.door_open)) begin
                    nxt_saved = nxt_state;
                    nxt_state = PH_PAUSED;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= PH_IDLE;
            saved        <= PH_IDLE;
            cnt          <= 8'd0;
            wash_len     <= 8'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.ph_light <= 8'h00;
            bus.buzz_en  <= 1'b0;
        end else begin
            state        <= nxt_state;
            saved        <= nxt_saved;
            cnt          <= nxt_cnt;
            if (start_ok)
                wash_len <= wash_secs(bus.mode);
            bus.busy     <= (nxt_state != PH_IDLE);
            bus.done     <= (nxt_state == PH_DONE) && (state != PH_DONE);
            bus.ph_light <= light_of(nxt_state);
            bus.buzz_en  <= (nxt_state == PH_DONE);
        end
    end

    assign bus.phase = state;

    bcd_down3 u_remain (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok),
        .load_val (total_bcd(bus.mode)),
        .dec      (tick && run && !rem_zero),
        .q        (bus.remain),
        .zero     (rem_zero)
    );
endmodule
